// File: rtl/sync_fifo_pkg.sv
// ----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared types and helpers for the sync_fifo_flags FIFO.
//   fifo_mode_e : read-side behaviour (registered standard or first-word-fall-through)
//   ptr_width() : pointer/count width for a given depth (address bits + wrap bit)
// ----------------------------------------------------------------------------
package sync_fifo_pkg;

    typedef enum logic {
        FIFO_STD,
        FIFO_FWFT
    } fifo_mode_e;

    // One extra bit beyond the address distinguishes full from empty and lets
    // count reach DEPTH.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// ----------------------------------------------------------------------------
// sync_fifo_flags_if
// Producer/consumer bus for sync_fifo_flags.
//   master : the FIFO's user (drives wr_enable, rd_enable, data_in)
//   slave  : the FIFO itself (drives data_out, data_valid, flags, count, errors)
// Signals:
//   wr_enable, data_in    write request and data
//   rd_enable             read request / FWFT acknowledge
//   data_out, data_valid  read data and its qualifier
//   full, empty, almost_full, almost_empty, count   occupancy status
//   overflow, underflow   one-cycle rejected-request pulses
// ----------------------------------------------------------------------------
interface sync_fifo_flags_if
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) ();

    localparam int unsigned CW = ptr_width(DEPTH);

    logic             wr_enable;
    logic             rd_enable;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_enable, rd_enable, data_in,
        input  data_out, data_valid, full, empty, almost_full, almost_empty,
        input  count, overflow, underflow
    );

    modport slave (
        input  wr_enable, rd_enable, data_in,
        output data_out, data_valid, full, empty, almost_full, almost_empty,
        output count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_flags_mem.sv
// ----------------------------------------------------------------------------
// fifo_mem
// WIDTH x DEPTH register array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports:
//   clk        rising-edge clock
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  read address
//   o_rd_data  read data (combinational from i_rd_addr)
// ----------------------------------------------------------------------------
module fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// ----------------------------------------------------------------------------
// sync_fifo_flags
// Single-clock FIFO with all DEPTH entries usable, exported occupancy count,
// almost-full/almost-empty thresholds, overflow/underflow pulses and a
// selectable standard (registered output) or FWFT read mode.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      sync_fifo_flags_if.slave (requests in; data, flags, count out)
// ----------------------------------------------------------------------------
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter fifo_mode_e  MODE     = FIFO_STD
) (
    input logic              clk,
    input logic              reset_n,
    sync_fifo_flags_if.slave bus
);

    localparam int unsigned   PW     = ptr_width(DEPTH);
    localparam int unsigned   AW     = PW - 1;
    localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [WIDTH-1:0] w_rd_data;

    // Pointers run modulo 2*DEPTH; the MSB is the wrap flag.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Acceptance uses pre-edge flags only, so a read never bypasses into an
    // empty FIFO and a write never slips into a full one.
    assign w_wr_acc = bus.wr_enable && !w_full;
    assign w_rd_acc = bus.rd_enable && !w_empty;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count     <= r_count + PW'(w_wr_acc) - PW'(w_rd_acc);
            r_overflow  <= bus.wr_enable && w_full;
            r_underflow <= bus.rd_enable && w_empty;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (bus.data_in),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    generate
        if (MODE == FIFO_STD) begin : g_std
            logic [WIDTH-1:0] r_data_out;
            logic             r_data_valid;

            // data_out holds its last value when no read is accepted.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_data_out   <= '0;
                    r_data_valid <= 1'b0;
                end else begin
                    r_data_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_data_out <= w_rd_data;
                    end
                end
            end

            assign bus.data_out   = r_data_out;
            assign bus.data_valid = r_data_valid;
        end else begin : g_fwft
            // Head word is presented directly from the array.
            assign bus.data_out   = w_empty ? '0 : w_rd_data;
            assign bus.data_valid = !w_empty;
        end
    endgenerate

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= AF_THR);
    assign bus.almost_empty = (r_count <= AE_THR);
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_flags
// Self-checking bench: one FIFO_STD and one FIFO_FWFT instance (WIDTH=8,
// DEPTH=4, AF_LEVEL=3, AE_LEVEL=1), each shadowed by a queue-based model.
// Inputs change on the falling edge, models update on the rising edge and
// outputs are compared on the falling edge.
// ----------------------------------------------------------------------------
module tb_sync_fifo_flags;
    import sync_fifo_pkg::*;

    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic clk = 1'b0;
    logic s_rst_n;
    logic f_rst_n;

    always #5 clk = ~clk;

    sync_fifo_flags_if #(.WIDTH(8), .DEPTH(DEPTH)) s_if ();
    sync_fifo_flags_if #(.WIDTH(8), .DEPTH(DEPTH)) f_if ();

    sync_fifo_flags #(
        .WIDTH (8), .DEPTH (DEPTH), .AF_LEVEL (AF), .AE_LEVEL (AE), .MODE (FIFO_STD)
    ) u_std (
        .clk     (clk),
        .reset_n (s_rst_n),
        .bus     (s_if.slave)
    );

    sync_fifo_flags #(
        .WIDTH (8), .DEPTH (DEPTH), .AF_LEVEL (AF), .AE_LEVEL (AE), .MODE (FIFO_FWFT)
    ) u_fwft (
        .clk     (clk),
        .reset_n (f_rst_n),
        .bus     (f_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference models ----------------
    logic [7:0] s_q[$];
    logic [7:0] s_dout  = 8'h00;
    bit         s_valid = 1'b0;
    bit         s_ovf   = 1'b0;
    bit         s_udf   = 1'b0;
    bit         s_chk   = 1'b0;
    bit         s_wa;

    logic [7:0] f_q[$];
    bit         f_ovf = 1'b0;
    bit         f_udf = 1'b0;
    bit         f_chk = 1'b0;
    bit         f_wa;

    initial forever begin
        @(posedge clk);
        if (!s_rst_n) begin
            s_q.delete();
            s_dout  = 8'h00;
            s_valid = 1'b0;
            s_ovf   = 1'b0;
            s_udf   = 1'b0;
            s_chk   = 1'b1;
        end else begin
            s_ovf   = s_if.wr_enable && (s_q.size() == DEPTH);
            s_udf   = s_if.rd_enable && (s_q.size() == 0);
            s_wa    = s_if.wr_enable && (s_q.size() < DEPTH);
            s_valid = 1'b0;
            if (s_if.rd_enable && s_q.size() != 0) begin
                s_dout  = s_q.pop_front();
                s_valid = 1'b1;
            end
            if (s_wa) s_q.push_back(s_if.data_in);
        end
    end

    initial forever begin
        @(posedge clk);
        if (!f_rst_n) begin
            f_q.delete();
            f_ovf = 1'b0;
            f_udf = 1'b0;
            f_chk = 1'b1;
        end else begin
            f_ovf = f_if.wr_enable && (f_q.size() == DEPTH);
            f_udf = f_if.rd_enable && (f_q.size() == 0);
            f_wa  = f_if.wr_enable && (f_q.size() < DEPTH);
            if (f_if.rd_enable && f_q.size() != 0) void'(f_q.pop_front());
            if (f_wa) f_q.push_back(f_if.data_in);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (s_chk) begin
            check("std_count", int'(s_if.count), s_q.size());
            check("std_empty", int'(s_if.empty), int'(s_q.size() == 0));
            check("std_full", int'(s_if.full), int'(s_q.size() == DEPTH));
            check("std_afull", int'(s_if.almost_full), int'(s_q.size() >= AF));
            check("std_aempty", int'(s_if.almost_empty), int'(s_q.size() <= AE));
            check("std_dout", int'(s_if.data_out), int'(s_dout));
            check("std_valid", int'(s_if.data_valid), int'(s_valid));
            check("std_ovf", int'(s_if.overflow), int'(s_ovf));
            check("std_udf", int'(s_if.underflow), int'(s_udf));
        end
        if (f_chk) begin
            check("fwft_count", int'(f_if.count), f_q.size());
            check("fwft_empty", int'(f_if.empty), int'(f_q.size() == 0));
            check("fwft_full", int'(f_if.full), int'(f_q.size() == DEPTH));
            check("fwft_afull", int'(f_if.almost_full), int'(f_q.size() >= AF));
            check("fwft_aempty", int'(f_if.almost_empty), int'(f_q.size() <= AE));
            check("fwft_dout", int'(f_if.data_out), (f_q.size() != 0) ? int'(f_q[0]) : 0);
            check("fwft_valid", int'(f_if.data_valid), int'(f_q.size() != 0));
            check("fwft_ovf", int'(f_if.overflow), int'(f_ovf));
            check("fwft_udf", int'(f_if.underflow), int'(f_udf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic s_cycle(input logic wr, input logic rd, input logic [7:0] d);
        s_if.wr_enable = wr;
        s_if.rd_enable = rd;
        s_if.data_in   = d;
        @(negedge clk);
    endtask

    task automatic f_cycle(input logic wr, input logic rd, input logic [7:0] d);
        f_if.wr_enable = wr;
        f_if.rd_enable = rd;
        f_if.data_in   = d;
        @(negedge clk);
    endtask

    logic [7:0] std_words [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    initial begin
        s_rst_n = 1'b0;
        f_rst_n = 1'b0;
        s_if.wr_enable = 1'b0; s_if.rd_enable = 1'b0; s_if.data_in = 8'h00;
        f_if.wr_enable = 1'b0; f_if.rd_enable = 1'b0; f_if.data_in = 8'h00;
        repeat (2) @(negedge clk);
        s_rst_n = 1'b1;
        f_rst_n = 1'b1;
        s_cycle(1'b0, 1'b0, 8'h00);

        // Reset state, hand-computed.
        check("lit_rst_empty", int'(s_if.empty), 1);
        check("lit_rst_aempty", int'(s_if.almost_empty), 1);
        check("lit_rst_full", int'(s_if.full), 0);
        check("lit_rst_count", int'(s_if.count), 0);
        check("lit_rst_dout", int'(s_if.data_out), 0);
        check("lit_rst_valid", int'(s_if.data_valid), 0);

        // Fill to full.
        for (int i = 0; i < 4; i++) begin
            s_cycle(1'b1, 1'b0, std_words[i]);
            check("lit_fill_count", int'(s_if.count), i + 1);
            check("lit_fill_afull", int'(s_if.almost_full), int'(i >= 2));
        end
        check("lit_full", int'(s_if.full), 1);

        // Overflow pulse, data rejected.
        s_cycle(1'b1, 1'b0, 8'hEE);
        check("lit_ovf_pulse", int'(s_if.overflow), 1);
        check("lit_ovf_count", int'(s_if.count), 4);
        s_cycle(1'b0, 1'b0, 8'h00);
        check("lit_ovf_clear", int'(s_if.overflow), 0);

        // Drain, one-cycle read latency.
        for (int i = 0; i < 4; i++) begin
            s_cycle(1'b0, 1'b1, 8'h00);
            check("lit_rd_dout", int'(s_if.data_out), int'(std_words[i]));
            check("lit_rd_valid", int'(s_if.data_valid), 1);
        end
        s_cycle(1'b0, 1'b0, 8'h00);
        check("lit_drain_empty", int'(s_if.empty), 1);
        check("lit_drain_valid", int'(s_if.data_valid), 0);

        // Underflow pulse, output held.
        s_cycle(1'b0, 1'b1, 8'h00);
        check("lit_udf_pulse", int'(s_if.underflow), 1);
        check("lit_udf_dout", int'(s_if.data_out), 'hD4);
        s_cycle(1'b0, 1'b0, 8'h00);
        check("lit_udf_clear", int'(s_if.underflow), 0);

        // Steady state at count 3 across pointer wrap.
        for (int i = 0; i < 3; i++) s_cycle(1'b1, 1'b0, 8'(8'h10 + i));
        for (int i = 0; i < 10; i++) begin
            s_cycle(1'b1, 1'b1, 8'(i));
            check("lit_pipe_count", int'(s_if.count), 3);
            check("lit_pipe_dout", int'(s_if.data_out), (i < 3) ? ('h10 + i) : (i - 3));
            check("lit_pipe_err", int'(s_if.overflow | s_if.underflow), 0);
        end

        // Reset mid-operation with a concurrent write.
        s_rst_n = 1'b0;
        s_cycle(1'b0, 1'b0, 8'h00);
        s_rst_n = 1'b1;
        s_cycle(1'b1, 1'b0, 8'h61);
        s_cycle(1'b1, 1'b0, 8'h62);
        check("lit_pre_rst_count", int'(s_if.count), 2);
        s_rst_n = 1'b0;
        s_cycle(1'b1, 1'b0, 8'h77);
        s_rst_n = 1'b1;
        check("lit_rst_wr_count", int'(s_if.count), 0);
        check("lit_rst_wr_empty", int'(s_if.empty), 1);
        s_cycle(1'b0, 1'b1, 8'h00);
        check("lit_rst_wr_udf", int'(s_if.underflow), 1);

        // Random traffic: fill-biased then drain-biased, rare resets.
        for (int i = 0; i < 400; i++) begin
            s_rst_n = ($urandom_range(0, 59) != 0);
            if (i < 200) s_cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 35, 8'($urandom));
            else         s_cycle($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 70, 8'($urandom));
        end
        s_rst_n = 1'b1;
        s_cycle(1'b0, 1'b0, 8'h00);

        // FWFT: word appears without a read request.
        f_cycle(1'b1, 1'b0, 8'h5A);
        check("lit_fwft_dout", int'(f_if.data_out), 'h5A);
        check("lit_fwft_valid", int'(f_if.data_valid), 1);
        f_cycle(1'b0, 1'b0, 8'h00);
        check("lit_fwft_hold", int'(f_if.data_out), 'h5A);
        f_cycle(1'b0, 1'b1, 8'h00);
        check("lit_fwft_ack_valid", int'(f_if.data_valid), 0);
        check("lit_fwft_ack_empty", int'(f_if.empty), 1);
        f_cycle(1'b1, 1'b0, 8'h11);
        f_cycle(1'b1, 1'b0, 8'h22);
        f_cycle(1'b0, 1'b1, 8'h00);
        check("lit_fwft_next", int'(f_if.data_out), 'h22);

        for (int i = 0; i < 400; i++) begin
            f_rst_n = ($urandom_range(0, 59) != 0);
            if (i < 200) f_cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 35, 8'($urandom));
            else         f_cycle($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 70, 8'($urandom));
        end
        f_rst_n = 1'b1;
        f_cycle(1'b0, 1'b0, 8'h00);
        f_cycle(1'b0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
